// File: rtl/fp_normaliser_pipe.sv
// Three-stage floating-point normaliser: leading-one detect, normalising shift, then round/pack/flags.
// Define FP_NORM_SUBNORM_EN to produce subnormals on underflow; otherwise tiny results flush to zero.
module fp_normaliser_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int IN_W   = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sig,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [IN_W-1:0]         in_mant,
  input  logic                    in_nan,
  input  logic                    in_inf,
  input  logic [1:0]              in_rm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   out_res,
  output logic [4:0]              out_exept
);
  localparam int FRAC_POS = IN_W - 2;
  localparam int LP_W     = $clog2(IN_W);
  localparam int E_W      = EXP_W + 2;
  localparam int NRM_W    = IN_W - 1;
  localparam int LOW_W    = IN_W - MANT_W - 2;
  localparam logic signed [E_W-1:0] E_MAX = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] E_ONE = E_W'(1);
  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;

  function automatic logic round_inc(input logic [1:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    case (rm)
      RM_RNE:  return g & (s | lsb);
      RM_RTZ:  return 1'b0;
      RM_RDN:  return sign & (g | s);
      default: return ~sign & (g | s);
    endcase
  endfunction

  logic adv;
  logic s1_valid_reg, s2_valid_reg, out_valid_reg;
  logic [EXP_W+MANT_W:0] out_res_reg, res_next;
  logic [4:0] out_exept_reg, exept_next;

  assign adv       = out_ready | ~out_valid_reg;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;
  assign out_res   = out_res_reg;
  assign out_exept = out_exept_reg;

  // Stage 1: leading-one detect on the raw mantissa
  logic [LP_W-1:0] lead_pos;
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < IN_W; i++)
      if (in_mant[i]) lead_pos = LP_W'(i);
  end

  logic                  s1_sig_reg, s1_nan_reg, s1_inf_reg, s1_zero_reg;
  logic [EXP_W-1:0]      s1_exp_reg;
  logic [IN_W-1:0]       s1_mant_reg;
  logic [1:0]            s1_rm_reg;
  logic [LP_W-1:0]       s1_lead_reg;

  // Stage 2: shift the leading one out of the top; it is implicit from here on
  logic [LP_W-1:0]       shamt;
  logic signed [E_W-1:0] e_next;
  assign shamt  = LP_W'(IN_W - 1) - s1_lead_reg;
  assign e_next = E_W'(s1_exp_reg) + E_W'(s1_lead_reg) - E_W'(FRAC_POS);

  logic                  s2_sig_reg, s2_nan_reg, s2_inf_reg, s2_zero_reg;
  logic [1:0]            s2_rm_reg;
  logic [NRM_W-1:0]      s2_norm_reg;
  logic signed [E_W-1:0] s2_e_reg;

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sig_reg  <= in_sig;
      s1_exp_reg  <= in_exp;
      s1_mant_reg <= in_mant;
      s1_nan_reg  <= in_nan;
      s1_inf_reg  <= in_inf;
      s1_rm_reg   <= in_rm;
      s1_lead_reg <= lead_pos;
      s1_zero_reg <= (in_mant == '0);
      s2_sig_reg  <= s1_sig_reg;
      s2_nan_reg  <= s1_nan_reg;
      s2_inf_reg  <= s1_inf_reg;
      s2_zero_reg <= s1_zero_reg;
      s2_rm_reg   <= s1_rm_reg;
      s2_norm_reg <= NRM_W'(s1_mant_reg << shamt);
      s2_e_reg    <= e_next;
    end
  end

  // Stage 3: round, detect overflow/underflow, pack
  logic [MANT_W-1:0]     frac_n;
  logic                  g_n, s_n, inc_n, ovf, uf, to_inf;
  logic [MANT_W:0]       rnd_n;
  logic signed [E_W-1:0] e_fin;

  assign frac_n = s2_norm_reg[NRM_W-1 -: MANT_W];
  assign g_n    = s2_norm_reg[LOW_W];
  assign s_n    = |s2_norm_reg[LOW_W-1:0];
  assign inc_n  = round_inc(s2_rm_reg, s2_sig_reg, frac_n[0], g_n, s_n);
  assign rnd_n  = {1'b0, frac_n} + (MANT_W+1)'(inc_n);
  assign e_fin  = s2_e_reg + E_W'(rnd_n[MANT_W]);
  assign ovf    = (e_fin >= E_MAX);
  assign uf     = (s2_e_reg < E_ONE);
  assign to_inf = (s2_rm_reg == RM_RNE) | ((s2_rm_reg == RM_RDN) & s2_sig_reg) |
                  ((s2_rm_reg == 2'b11) & ~s2_sig_reg);

`ifdef FP_NORM_SUBNORM_EN
  localparam int W_W = MANT_W + 3;
  logic [W_W-1:0]  sub_w, sub_shifted;
  logic [E_W-1:0]  sub_sh_raw, sub_sh;
  logic            sub_lost, inc_u;
  logic [MANT_W:0] rnd_u;

  // Hidden one, fraction, guard, sticky shifted right together; lost bits fold into sticky
  assign sub_w       = {1'b1, frac_n, g_n, s_n};
  assign sub_sh_raw  = E_ONE - s2_e_reg;
  assign sub_sh      = (sub_sh_raw > E_W'(W_W - 1)) ? E_W'(W_W - 1) : sub_sh_raw;
  assign sub_shifted = sub_w >> sub_sh;
  assign sub_lost    = |(sub_w & ~({W_W{1'b1}} << sub_sh));
  assign inc_u       = round_inc(s2_rm_reg, s2_sig_reg, sub_shifted[2], sub_shifted[1],
                                 sub_shifted[0] | sub_lost);
  assign rnd_u       = sub_shifted[W_W-1:2] + (MANT_W+1)'(inc_u);
`endif

  always_comb begin
    res_next   = '0;
    exept_next = '0;
    if (s2_nan_reg) begin
      res_next   = {1'b0, {EXP_W{1'b1}}, {MANT_W{1'b1}}};
      exept_next = 5'b00001;
    end else if (s2_inf_reg) begin
      res_next = {s2_sig_reg, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (s2_zero_reg) begin
      res_next = {s2_sig_reg, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
    end else if (ovf) begin
      res_next   = to_inf ? {s2_sig_reg, {EXP_W{1'b1}}, {MANT_W{1'b0}}}
                          : {s2_sig_reg, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
      exept_next = 5'b10100;
    end else if (uf) begin
`ifdef FP_NORM_SUBNORM_EN
      res_next   = {s2_sig_reg, {(EXP_W-1){1'b0}}, rnd_u[MANT_W], rnd_u[MANT_W-1:0]};
      exept_next = {sub_shifted[1] | sub_shifted[0] | sub_lost, ~rnd_u[MANT_W], 3'b000};
`else
      res_next   = {s2_sig_reg, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
      exept_next = 5'b11000;
`endif
    end else begin
      res_next   = {s2_sig_reg, e_fin[EXP_W-1:0], rnd_n[MANT_W-1:0]};
      exept_next = {g_n | s_n, 4'b0000};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_res_reg   <= '0;
      out_exept_reg <= '0;
    end else if (adv) begin
      s1_valid_reg  <= in_valid;
      s2_valid_reg  <= s1_valid_reg;
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_res_reg   <= res_next;
        out_exept_reg <= exept_next;
      end
    end
  end
endmodule

// File: tb/tb_fp_normaliser_pipe.sv
// Directed-vector bench for fp_normaliser_pipe (default parameters, single precision).
module tb_fp_normaliser_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_sig, in_nan, in_inf, out_valid, out_ready;
  logic [7:0]  in_exp;
  logic [49:0] in_mant;
  logic [1:0]  in_rm;
  logic [31:0] out_res;
  logic [4:0]  out_exept;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RDN = 2'b10, RUP = 2'b11;
  localparam logic [49:0] B0    = 50'd1;
  localparam logic [49:0] B24   = 50'd1 << 24;
  localparam logic [49:0] B25   = 50'd1 << 25;
  localparam logic [49:0] B47   = 50'd1 << 47;
  localparam logic [49:0] B48   = 50'd1 << 48;
  localparam logic [49:0] B49   = 50'd1 << 49;
  localparam logic [49:0] ALL49 = (50'd1 << 49) - 50'd1;

  typedef struct packed {
    logic        sig;
    logic [7:0]  exp;
    logic [49:0] mant;
    logic [1:0]  rm;
    logic        nan;
    logic        inf;
    logic [31:0] res;
    logic [4:0]  ex;
  } vec_t;

  always #5 clk = ~clk;

  fp_normaliser_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sig(in_sig), .in_exp(in_exp), .in_mant(in_mant), .in_nan(in_nan),
    .in_inf(in_inf), .in_rm(in_rm), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_exept(out_exept)
  );

  task automatic set_beat(input vec_t v);
    in_sig  = v.sig;
    in_exp  = v.exp;
    in_mant = v.mant;
    in_rm   = v.rm;
    in_nan  = v.nan;
    in_inf  = v.inf;
  endtask

  // Single beat with out_ready=1; lat counts rising edges from the accepting edge to out_valid
  task automatic run_one(input vec_t v, output logic [31:0] res, output logic [4:0] ex,
                         output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    set_beat(v);
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = out_res;
    ex  = out_exept;
    if (!out_valid) begin
      n_total++;
      $display("FAIL timeout: out_valid never rose (got 0, want 1)");
    end
    $display("beat sig=%0b exp=%0d mant=%h rm=%0d nan=%0b inf=%0b -> res=%h exept=%b lat=%0d",
             v.sig, v.exp, v.mant, v.rm, v.nan, v.inf, res, ex, lat);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; out_ready = 1'b1;
    set_beat('{1'b0, 8'd127, B48, RNE, 1'b0, 1'b0, 32'h0, 5'h0});
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_total++;
    if (out_res !== 32'h0 || out_exept !== 5'h0)
      $display("FAIL reset_data: got %h/%b want 0/0", out_res, out_exept);
    else n_pass++;
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else n_pass++;
    begin
      int seen = 0;
      repeat (5) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      n_total++;
      if (seen != 0) $display("FAIL reset_ignored: got %0d outputs want 0", seen); else n_pass++;
    end
  endtask

  task automatic test_basic;
    logic [31:0] r; logic [4:0] e; int lat;
    run_one('{1'b0, 8'd127, B48, RNE, 1'b0, 1'b0, 32'h0, 5'h0}, r, e, lat);
    n_total++;
    if (r !== 32'h3F800000) $display("FAIL basic_res: got %h want 3f800000", r); else n_pass++;
    n_total++;
    if (e !== 5'b00000) $display("FAIL basic_exept: got %b want 00000", e); else n_pass++;
    n_total++;
    if (lat != 3) $display("FAIL basic_latency: got %0d want 3", lat); else n_pass++;
  endtask

  task automatic test_rounding;
    vec_t q[$];
    logic [31:0] r; logic [4:0] e; int lat;
    q.push_back('{1'b0, 8'd127, B49,             RNE, 1'b0, 1'b0, 32'h40000000, 5'b00000});
    q.push_back('{1'b0, 8'd127, B48 | B24,       RNE, 1'b0, 1'b0, 32'h3F800000, 5'b10000});
    q.push_back('{1'b0, 8'd127, B48 | B24,       RUP, 1'b0, 1'b0, 32'h3F800001, 5'b10000});
    q.push_back('{1'b0, 8'd127, B48 | B24,       RTZ, 1'b0, 1'b0, 32'h3F800000, 5'b10000});
    q.push_back('{1'b1, 8'd127, B48 | B24,       RDN, 1'b0, 1'b0, 32'hBF800001, 5'b10000});
    q.push_back('{1'b0, 8'd127, B48 | B25 | B24, RNE, 1'b0, 1'b0, 32'h3F800002, 5'b10000});
    q.push_back('{1'b0, 8'd127, ALL49,           RNE, 1'b0, 1'b0, 32'h40000000, 5'b10000});
    q.push_back('{1'b0, 8'd127, B0,              RNE, 1'b0, 1'b0, 32'h27800000, 5'b00000});
    foreach (q[i]) begin
      run_one(q[i], r, e, lat);
      n_total++;
      if (r !== q[i].res || e !== q[i].ex)
        $display("FAIL round_%0d: got %h/%b want %h/%b", i, r, e, q[i].res, q[i].ex);
      else n_pass++;
    end
  endtask

  task automatic test_overflow;
    vec_t q[$];
    logic [31:0] r; logic [4:0] e; int lat;
    q.push_back('{1'b0, 8'd254, B49,   RNE, 1'b0, 1'b0, 32'h7F800000, 5'b10100});
    q.push_back('{1'b0, 8'd254, B49,   RTZ, 1'b0, 1'b0, 32'h7F7FFFFF, 5'b10100});
    q.push_back('{1'b1, 8'd254, B49,   RDN, 1'b0, 1'b0, 32'hFF800000, 5'b10100});
    q.push_back('{1'b1, 8'd254, B49,   RUP, 1'b0, 1'b0, 32'hFF7FFFFF, 5'b10100});
    q.push_back('{1'b0, 8'd254, ALL49, RNE, 1'b0, 1'b0, 32'h7F800000, 5'b10100});
    q.push_back('{1'b0, 8'd254, B48,   RNE, 1'b0, 1'b0, 32'h7F000000, 5'b00000});
    foreach (q[i]) begin
      run_one(q[i], r, e, lat);
      n_total++;
      if (r !== q[i].res || e !== q[i].ex)
        $display("FAIL ovf_%0d: got %h/%b want %h/%b", i, r, e, q[i].res, q[i].ex);
      else n_pass++;
    end
  endtask

  task automatic test_special;
    vec_t q[$];
    logic [31:0] r; logic [4:0] e; int lat;
    q.push_back('{1'b1, 8'd5,   50'd123, RNE, 1'b1, 1'b1, 32'h7FFFFFFF, 5'b00001});
    q.push_back('{1'b1, 8'd5,   50'd123, RNE, 1'b0, 1'b1, 32'hFF800000, 5'b00000});
    q.push_back('{1'b1, 8'd100, 50'd0,   RNE, 1'b0, 1'b0, 32'h80000000, 5'b00000});
    q.push_back('{1'b0, 8'd255, 50'd0,   RUP, 1'b0, 1'b0, 32'h00000000, 5'b00000});
    foreach (q[i]) begin
      run_one(q[i], r, e, lat);
      n_total++;
      if (r !== q[i].res || e !== q[i].ex)
        $display("FAIL special_%0d: got %h/%b want %h/%b", i, r, e, q[i].res, q[i].ex);
      else n_pass++;
    end
  endtask

  task automatic test_underflow;
    vec_t q[$];
    logic [31:0] r; logic [4:0] e; int lat;
    q.push_back('{1'b0, 8'd1, B48, RNE, 1'b0, 1'b0, 32'h00800000, 5'b00000});
`ifdef FP_NORM_SUBNORM_EN
    q.push_back('{1'b0, 8'd1, B47,      RNE, 1'b0, 1'b0, 32'h00400000, 5'b01000});
    q.push_back('{1'b1, 8'd1, B47 | B0, RNE, 1'b0, 1'b0, 32'h80400000, 5'b11000});
    q.push_back('{1'b0, 8'd0, B0,       RUP, 1'b0, 1'b0, 32'h00000001, 5'b11000});
    q.push_back('{1'b0, 8'd0, ALL49,    RNE, 1'b0, 1'b0, 32'h00800000, 5'b10000});
`else
    q.push_back('{1'b0, 8'd1, B47,      RNE, 1'b0, 1'b0, 32'h00000000, 5'b11000});
    q.push_back('{1'b1, 8'd1, B47 | B0, RNE, 1'b0, 1'b0, 32'h80000000, 5'b11000});
    q.push_back('{1'b0, 8'd0, B0,       RUP, 1'b0, 1'b0, 32'h00000000, 5'b11000});
    q.push_back('{1'b0, 8'd0, ALL49,    RNE, 1'b0, 1'b0, 32'h00000000, 5'b11000});
`endif
    foreach (q[i]) begin
      run_one(q[i], r, e, lat);
      n_total++;
      if (r !== q[i].res || e !== q[i].ex)
        $display("FAIL uf_%0d: got %h/%b want %h/%b", i, r, e, q[i].res, q[i].ex);
      else n_pass++;
    end
  endtask

  // Beat k (1..8): exp 127, fraction k, sign k[0] -> exact result {k[0], 127, k}
  task automatic test_back_to_back;
    int idx = 0, rcnt = 0, cyc = 0, extra = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_res = '0, want;
    logic take_in, take_out;
    while (rcnt < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      if (idx < 8) begin
        set_beat('{1'(idx + 1), 8'd127, B48 | (50'(idx + 1) << 25), RNE, 1'b0, 1'b0,
                   32'h0, 5'h0});
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        n_total++;
        if (out_valid !== 1'b1 || out_res !== prev_res)
          $display("FAIL b2b_hold: got %b/%h want 1/%h", out_valid, out_res, prev_res);
        else n_pass++;
      end
      if (out_valid && !out_ready) begin
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL b2b_ready: got %b want 0", in_ready);
        else n_pass++;
      end
      take_in  = in_valid && in_ready;
      take_out = out_valid && out_ready;
      if (take_out) begin
        want = {1'(rcnt + 1), 8'd127, 23'(rcnt + 1)};
        n_total++;
        if (out_res !== want || out_exept !== 5'b0)
          $display("FAIL b2b_res_%0d: got %h/%b want %h/00000", rcnt, out_res, out_exept, want);
        else n_pass++;
        $display("b2b result %0d res=%h exept=%b cycle=%0d", rcnt, out_res, out_exept, cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_res;
      @(posedge clk);
      if (take_in) idx++;
      if (take_out) rcnt++;
      cyc++;
    end
    n_total++;
    if (rcnt != 8) $display("FAIL b2b_count: got %0d want 8", rcnt); else n_pass++;
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    n_total++;
    if (extra != 0) $display("FAIL b2b_extra: got %0d want 0", extra); else n_pass++;
  endtask

  task automatic test_reset_flush;
    int seen = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_beat('{1'b0, 8'(120 + k), B48, RNE, 1'b0, 1'b0, 32'h0, 5'h0});
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    set_beat('{1'b1, 8'd130, B48, RNE, 1'b0, 1'b0, 32'h0, 5'h0});
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0 || out_res !== 32'h0)
      $display("FAIL flush_valid: got %b/%h want 0/00000000", out_valid, out_res);
    else n_pass++;
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL flush_stale: got %0d outputs want 0", seen); else n_pass++;
    $display("flush done stale_outputs=%0d", seen);
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    in_sig = 1'b0; in_exp = '0; in_mant = '0; in_rm = RNE; in_nan = 1'b0; in_inf = 1'b0;
    test_reset;
    test_basic;
    test_rounding;
    test_overflow;
    test_special;
    test_underflow;
    test_back_to_back;
    test_reset_flush;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
